// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM states and command opcodes.
// Optional feature macro used by the sequencer: COUNTER_PRESCALE_EN.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    typedef logic [1:0] op_t;

    localparam op_t OP_START = 2'b00;
    localparam op_t OP_STOP  = 2'b01;
    localparam op_t OP_PAUSE = 2'b10;
    localparam op_t OP_CLEAR = 2'b11;

    // A run is in progress (counting or paused).
    function automatic logic is_active(input state_t s);
        return (s == RUN) || (s == HOLD);
    endfunction

endpackage

// File: rtl/tff_up_counter.sv
// WIDTH-bit up counter built from per-bit T flip-flops.
// Bit i toggles when en is high and all lower bits are 1; clr beats en.
module tff_up_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] t;

    // Toggle enables: ripple AND of the lower bits, gated by en.
    always_comb begin
        logic carry;
        carry = en;
        t     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]  = carry;
            carry = carry & q[i];
        end
    end

    // T flip-flop bank; synchronous reset and clear take priority.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            q <= '0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven run controller around a T-flip-flop up counter.
// START/STOP/PAUSE/CLEAR arrive over valid/ready; free-run or one-shot at a limit.
// Optional feature macro: COUNTER_PRESCALE_EN adds a prescale input that divides ticks.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_limit,
    input  logic                  cmd_oneshot,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  paused,
    output logic                  wrap,
    output logic                  done
);

`ifndef COUNTER_PRESCALE_EN
    // Without the feature a zero divider makes every RUN cycle a tick.
    logic [PRESCALE_W-1:0] prescale;
    assign prescale = '0;
`endif

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      limit_q, limit_d;
    logic                  oneshot_q, oneshot_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  wrap_d;

    logic accept;
    logic presc_hit;
    logic tick;
    logic at_limit;
    logic cnt_en;
    logic cnt_clr;

    assign cmd_ready = (state_q != DONE);

    // Handshake and tick qualification.
    always_comb begin
        accept    = cmd_valid & cmd_ready;
        presc_hit = (presc_q >= prescale);
        tick      = (state_q == RUN) & presc_hit;
        at_limit  = (count == limit_q);
    end

    // Next-state decode; an accepted command always drops a coincident tick.
    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        oneshot_d = oneshot_q;
        presc_d   = presc_q;
        wrap_d    = 1'b0;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;

        if (state_q == RUN) begin
            presc_d = presc_hit ? '0 : presc_q + PRESCALE_W'(1);
        end

        if (state_q == DONE) begin
            state_d = IDLE;
        end else if (accept) begin
            case (cmd_op)
                OP_START: begin
                    limit_d   = cmd_limit;
                    oneshot_d = cmd_oneshot;
                    cnt_clr   = 1'b1;
                    presc_d   = '0;
                    state_d   = RUN;
                end
                OP_STOP: begin
                    if (is_active(state_q)) begin
                        state_d = IDLE;
                    end
                end
                OP_PAUSE: begin
                    if (state_q == RUN) begin
                        state_d = HOLD;
                    end else if (state_q == HOLD) begin
                        state_d = RUN;
                    end
                end
                OP_CLEAR: begin
                    cnt_clr = 1'b1;
                    presc_d = '0;
                end
                default: ;
            endcase
        end else if (tick) begin
            if (!at_limit) begin
                cnt_en = 1'b1;
            end else if (!oneshot_q) begin
                cnt_clr = 1'b1;
                wrap_d  = 1'b1;
            end else begin
                state_d = DONE;
            end
        end
    end

    // FSM state, latched run parameters and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            limit_q   <= '0;
            oneshot_q <= 1'b0;
            presc_q   <= '0;
            busy      <= 1'b0;
            paused    <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            oneshot_q <= oneshot_d;
            presc_q   <= presc_d;
            busy      <= is_active(state_d);
            paused    <= (state_d == HOLD);
            wrap      <= wrap_d;
            done      <= (state_d == DONE);
        end
    end

    tff_up_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clock(clock),
        .reset(reset),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .q    (count)
    );

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed scenarios with literal
// expectations, then randomized commands checked every cycle against a model.
// Honours COUNTER_PRESCALE_EN when defined.
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    localparam int W = 3;
    localparam int PW = 4;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_limit;
    logic          cmd_oneshot;
    logic [PW-1:0] prescale;
    logic [W-1:0]  count;
    logic          busy;
    logic          paused;
    logic          wrap;
    logic          done;

    int checks = 0;
    int errors = 0;

    counter_sequencer #(
        .WIDTH     (W),
        .PRESCALE_W(PW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_limit  (cmd_limit),
        .cmd_oneshot(cmd_oneshot),
`ifdef COUNTER_PRESCALE_EN
        .prescale   (prescale),
`endif
        .count      (count),
        .busy       (busy),
        .paused     (paused),
        .wrap       (wrap),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode of the run: 0 idle, 1 counting, 2 paused, 3 finished (one cycle).
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    bit model_valid = 0;
    int m_mode = M_IDLE;
    int m_cnt  = 0;
    int m_lim  = 0;
    bit m_os   = 0;
    bit m_wrap = 0;
    int m_pc   = 0;

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                model_valid = 1;
                m_mode = M_IDLE;
                m_cnt  = 0;
                m_lim  = 0;
                m_os   = 0;
                m_wrap = 0;
                m_pc   = 0;
            end else if (model_valid) begin
                int  div;
                bit  acc;
                bit  tick;
`ifdef COUNTER_PRESCALE_EN
                div = int'(prescale);
`else
                div = 0;
`endif
                acc    = cmd_valid && (m_mode != M_DONE);
                tick   = (m_mode == M_RUN) && (m_pc >= div);
                m_wrap = 0;
                if (m_mode == M_RUN) m_pc = (m_pc >= div) ? 0 : m_pc + 1;
                if (m_mode == M_DONE) begin
                    m_mode = M_IDLE;
                end else if (acc) begin
                    if (cmd_op == OP_START) begin
                        m_lim = int'(cmd_limit);
                        m_os  = cmd_oneshot;
                        m_cnt = 0;
                        m_pc  = 0;
                        m_mode = M_RUN;
                    end else if (cmd_op == OP_STOP) begin
                        if (m_mode != M_IDLE) m_mode = M_IDLE;
                    end else if (cmd_op == OP_PAUSE) begin
                        if (m_mode == M_RUN) m_mode = M_HOLD;
                        else if (m_mode == M_HOLD) m_mode = M_RUN;
                    end else begin
                        m_cnt = 0;
                        m_pc  = 0;
                    end
                end else if (tick) begin
                    if (m_cnt < m_lim) begin
                        m_cnt = m_cnt + 1;
                    end else if (!m_os) begin
                        m_cnt  = 0;
                        m_wrap = 1;
                    end else begin
                        m_mode = M_DONE;
                    end
                end
            end
        end
    end

    // Compare process: outputs are stable mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (model_valid) begin
                chk("model count", 32'(count), 32'(m_cnt));
                chk("model busy", 32'(busy), 32'(m_mode == M_RUN || m_mode == M_HOLD));
                chk("model paused", 32'(paused), 32'(m_mode == M_HOLD));
                chk("model wrap", 32'(wrap), 32'(m_wrap));
                chk("model done", 32'(done), 32'(m_mode == M_DONE));
                chk("model cmd_ready", 32'(cmd_ready), 32'(m_mode != M_DONE));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clock);
    endtask

    // Present a command for exactly one edge; returns at the following negedge.
    task automatic send(input logic [1:0] op, input logic [W-1:0] lim, input logic os);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_limit   = lim;
        cmd_oneshot = os;
        @(negedge clock);
        cmd_valid   = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_limit   = '0;
        cmd_oneshot = 1'b0;
        prescale    = '0;

        // Reset held for two edges.
        step();
        step();
        chk("reset count", 32'(count), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset cmd_ready", 32'(cmd_ready), 1);
        chk("reset done", 32'(done), 0);
        chk("reset wrap", 32'(wrap), 0);
        reset = 1'b0;

        // Free-run to limit 5 and wrap.
        send(OP_START, 3'd5, 1'b0);
        chk("fr start count", 32'(count), 0);
        chk("fr start busy", 32'(busy), 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("fr count", 32'(count), 32'(i));
            chk("fr no wrap", 32'(wrap), 0);
        end
        step();
        chk("fr wrap count", 32'(count), 0);
        chk("fr wrap pulse", 32'(wrap), 1);
        chk("fr wrap busy", 32'(busy), 1);
        step();
        chk("fr after wrap count", 32'(count), 1);
        chk("fr wrap cleared", 32'(wrap), 0);

        // One-shot to limit 3.
        send(OP_START, 3'd3, 1'b1);
        chk("os start count", 32'(count), 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("os count", 32'(count), 32'(i));
        end
        step();
        chk("os done", 32'(done), 1);
        chk("os ready low", 32'(cmd_ready), 0);
        chk("os done count", 32'(count), 3);
        step();
        chk("os idle done", 32'(done), 0);
        chk("os idle busy", 32'(busy), 0);
        chk("os idle count", 32'(count), 3);
        chk("os idle ready", 32'(cmd_ready), 1);

        // Pause at 2 for four cycles, then resume.
        send(OP_START, 3'd7, 1'b0);
        step();
        step();
        chk("pause pre count", 32'(count), 2);
        send(OP_PAUSE, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("pause hold count", 32'(count), 2);
            chk("pause flag", 32'(paused), 1);
            if (i < 3) step();
        end
        send(OP_PAUSE, 3'd0, 1'b0);
        chk("resume paused", 32'(paused), 0);
        step();
        chk("resume count", 32'(count), 3);

        // CLEAR coinciding with a tick at 4, then STOP at 6.
        step();
        chk("clear pre count", 32'(count), 4);
        send(OP_CLEAR, 3'd0, 1'b0);
        chk("clear count", 32'(count), 0);
        chk("clear busy", 32'(busy), 1);
        for (int i = 0; i < 6; i++) step();
        chk("stop pre count", 32'(count), 6);
        send(OP_STOP, 3'd0, 1'b0);
        chk("stop count", 32'(count), 6);
        chk("stop busy", 32'(busy), 0);
        step();
        chk("stop idle count", 32'(count), 6);

        // Limit 0 free-run: wrap every tick.
        send(OP_START, 3'd0, 1'b0);
        step();
        chk("lim0 wrap", 32'(wrap), 1);
        chk("lim0 count", 32'(count), 0);
        send(OP_STOP, 3'd0, 1'b0);

`ifdef COUNTER_PRESCALE_EN
        // Prescale 2: one increment every third RUN cycle.
        prescale = 4'd2;
        send(OP_START, 3'd7, 1'b0);
        step();
        step();
        chk("ps hold count", 32'(count), 0);
        step();
        chk("ps first tick", 32'(count), 1);
        step();
        step();
        chk("ps hold 2", 32'(count), 1);
        step();
        chk("ps second tick", 32'(count), 2);
        prescale = '0;
`endif

        // Reset mid-run with a concurrent command.
        send(OP_START, 3'd7, 1'b0);
        step();
        step();
        reset       = 1'b1;
        cmd_valid   = 1'b1;
        cmd_op      = OP_START;
        cmd_limit   = 3'd5;
        step();
        chk("mid reset count", 32'(count), 0);
        chk("mid reset busy", 32'(busy), 0);
        chk("mid reset paused", 32'(paused), 0);
        chk("mid reset wrap", 32'(wrap), 0);
        chk("mid reset done", 32'(done), 0);
        chk("mid reset ready", 32'(cmd_ready), 1);
        reset     = 1'b0;
        cmd_valid = 1'b0;

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 4000; n++) begin
            reset       = ($urandom_range(0, 299) == 0);
            cmd_valid   = ($urandom_range(0, 5) == 0);
            cmd_op      = ($urandom_range(0, 9) < 4) ? OP_START : 2'($urandom_range(1, 3));
            cmd_limit   = W'($urandom_range(0, 7));
            cmd_oneshot = 1'($urandom_range(0, 1));
`ifdef COUNTER_PRESCALE_EN
            prescale    = PW'($urandom_range(0, 3));
`endif
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
